// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
//
// Every pattern here is active-low, with bit order g f e d c b a (bit6..bit0).
// A 0 bit lights a segment, so SEG_BLANK (all ones) turns every segment off.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // A digit slot is dark during its anti-ghost lead-in and lit for the rest of the slot.
    typedef enum logic {
        PHASE_DARK = 1'b0,
        PHASE_LIT  = 1'b1
    } slot_phase_e;

    // Returns the full hex glyph for a nibble.
    // Blanking codes 10..15 outside hex mode is left to the caller.
    function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_A;
            4'hB:    pat = SEG_B;
            4'hC:    pat = SEG_C;
            4'hD:    pat = SEG_D;
            4'hE:    pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder.
//
// Ports:
//   nibble   : digit code 0..15
//   blank    : force all segments off (used for leading-zero suppression)
//   hex_mode : 1 = codes 10..15 are shown as A b C d E F, 0 = codes 10..15 are blank
//   seg      : active-low segment pattern, g f e d c b a
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    // Start from the hex glyph, then blank it if the caller asks.
    // Outside hex mode, codes 10..15 are blanked as well.
    always_comb begin
        seg = hex_pattern(nibble);
        if (blank || (!hex_mode && (nibble > 4'd9))) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with a double-buffered frame.
//
// Scans one digit per refresh slot and drives a one-hot active-low anode.
// Each slot starts with a short all-dark period so the previous digit does not ghost.
// New frames are loaded into a shadow buffer and are committed only at a frame boundary,
// or at once while the display is dark, so a frame never tears.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   enable     : 1 = scanning; 0 = display dark and scan position frozen
//   load       : one-cycle strobe that captures digits/dp_in
//   digits     : nibble k is digit k (digit 0 is the rightmost digit)
//   dp_in      : bit k is the decimal point of digit k (1 = lit)
//   lz_en      : leading-zero suppression, sampled live
//   seg, dp    : active-low segments (g..a) and active-low decimal point
//   an         : active-low one-hot anode select
//   frame_tick : one-cycle pulse after the last digit slot ends
//   pending    : the shadow buffer holds data that is not yet committed
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   active_dp;

    logic                    slot_last;
    logic                    frame_wrap;
    logic                    commit;
    logic [4*NUM_DIGITS-1:0] view_digits;
    logic [NUM_DIGITS-1:0]   view_dp;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;
    slot_phase_e             phase;

    // Scan timing and commit decision.
    // A commit happens in the cycle where frame_tick is high, and also on any dark cycle
    // while data is pending. The commit takes effect at the end of that cycle.
    always_comb begin
        slot_last  = (presc == PRESC_LAST);
        frame_wrap = enable && slot_last && (idx == IDX_LAST);
        commit     = frame_tick || (!enable && pending);
    end

    // The digits that are displayed this cycle.
    // In a commit cycle the outgoing data is forwarded, so the first lit cycle of the new
    // frame never shows stale digits, even with no blanking lead-in.
    always_comb begin
        view_digits = active_digits;
        view_dp     = active_dp;
        if (commit) begin
            view_digits = load ? digits : shadow_digits;
            view_dp     = load ? dp_in  : shadow_dp;
        end
    end

    // Leading-zero suppression.
    // Walk down from the top digit while each nibble is zero and its decimal point is dark.
    // A lit decimal point keeps its own digit visible and stops suppression below it.
    // Digit 0 is never suppressed.
    always_comb begin : lz_chain
        logic run;
        run      = 1'b1;
        suppress = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run         = run && (view_digits[4*k +: 4] == 4'd0) && !view_dp[k];
            suppress[k] = lz_en && run && (k != 0);
        end
    end

    // Select the digit for the current slot.
    // The slot is dark during the anti-ghost lead-in and whenever scanning is off.
    always_comb begin
        cur_nibble = view_digits[4*idx +: 4];
        if (!enable || (int'(presc) < BLANK_CYCLES)) begin
            phase = PHASE_DARK;
        end else begin
            phase = PHASE_LIT;
        end
    end

    seg7_decode u_decode (
        .nibble   (cur_nibble),
        .blank    (suppress[idx]),
        .hex_mode (HEX_MODE != 0),
        .seg      (cur_seg)
    );

    // Prescaler and digit index.
    // Both freeze while enable is low, so scanning resumes exactly where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (enable) begin
            if (slot_last) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Shadow/active frame buffers.
    // A load that coincides with a commit goes straight to the active frame. The shadow
    // copy is updated too, so a later commit with nothing pending re-commits the same data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            active_digits <= '0;
            active_dp     <= '0;
            pending       <= 1'b0;
        end else begin
            if (load) begin
                shadow_digits <= digits;
                shadow_dp     <= dp_in;
            end
            if (commit) begin
                active_digits <= view_digits;
                active_dp     <= view_dp;
                pending       <= 1'b0;
            end else if (load) begin
                pending       <= 1'b1;
            end
        end
    end

    // Registered display outputs.
    // They show this cycle's slot in the next cycle, which is the one-cycle output latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (phase == PHASE_LIT) begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= cur_seg;
                dp  <= ~view_dp[idx];
            end else begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule
